// File: rtl/cla_adder_pipe_pkg.sv
// Shared types and lookahead helpers for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int unsigned GROUP_W_DEFAULT = 5;

    // Widest vector the lookahead helpers accept (bits per group or number of groups).
    localparam int unsigned CLA_MAX_N = 32;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Parallel carry vector: c[i+1] is the OR of every generate term at or below i,
    // each ANDed with the propagate terms above it, plus cin ANDed with all propagates.
    // Each carry is a flat sum-of-products; no carry feeds another.
    function automatic logic [CLA_MAX_N:0] cla_carries(
        input logic [CLA_MAX_N-1:0] g,
        input logic [CLA_MAX_N-1:0] p,
        input logic                 cin,
        input int unsigned          n
    );
        logic [CLA_MAX_N:0] c;
        logic               acc;
        logic               prod;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < n; i++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int unsigned j = i + 1; j > 0; j--) begin
                acc  = acc | (g[j-1] & prod);
                prod = prod & p[j-1];
            end
            acc    = acc | (cin & prod);
            c[i+1] = acc;
        end
        return c;
    endfunction

    // Group generate: carry out of an n-bit block with zero carry in.
    function automatic logic cla_gen(
        input logic [CLA_MAX_N-1:0] g,
        input logic [CLA_MAX_N-1:0] p,
        input int unsigned          n
    );
        logic [CLA_MAX_N:0] c;
        c = cla_carries(g, p, 1'b0, n);
        return c[n];
    endfunction

endpackage

// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle for cla_adder_pipe.
interface cla_adder_pipe_if #(
    parameter int unsigned WIDTH = 20
) ();

    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             sub_i;
    logic             cin_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;

    // Upstream producer / downstream consumer side.
    modport master (
        output in_valid_i, a_i, b_i, sub_i, cin_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o, cout_o, ovf_o
    );

    // Adder side.
    modport slave (
        input  in_valid_i, a_i, b_i, sub_i, cin_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o, cout_o, ovf_o
    );

endinterface

// File: rtl/cla_adder_pipe_group.sv
// One lookahead group: in-group carries from the group carry-in, sum bits and
// the group generate/propagate terms. Purely combinational.
module cla_group
    import cla_pkg::*;
#(
    parameter int unsigned GROUP_W = GROUP_W_DEFAULT
) (
    input  logic [GROUP_W-1:0] p_i,
    input  logic [GROUP_W-1:0] g_i,
    input  logic               cin_i,
    output logic [GROUP_W-1:0] sum_o,
    output logic               gg_o,
    output logic               pg_o
);

    logic [GROUP_W-1:0] c;

    // Bit carries by lookahead from cin_i, then sum and group terms.
    always_comb begin
        c     = GROUP_W'(cla_carries(CLA_MAX_N'(g_i), CLA_MAX_N'(p_i), cin_i, GROUP_W));
        sum_o = p_i ^ c;
        gg_o  = cla_gen(CLA_MAX_N'(g_i), CLA_MAX_N'(p_i), GROUP_W);
        pg_o  = &p_i;
    end

endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 registers bit and group generate/propagate terms; stage 2 resolves the
// group carries and sums into the output register.
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH   = 20,
    parameter int unsigned GROUP_W = GROUP_W_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    cla_adder_pipe_if.slave bus
);

    localparam int unsigned NUM_GROUPS = WIDTH / GROUP_W;

    if ((WIDTH % GROUP_W) != 0) begin : g_bad_width
        $error("cla_adder_pipe: WIDTH must be a multiple of GROUP_W");
    end
    if ((GROUP_W > CLA_MAX_N) || (NUM_GROUPS > CLA_MAX_N)) begin : g_bad_size
        $error("cla_adder_pipe: GROUP_W and NUM_GROUPS must not exceed CLA_MAX_N");
    end

    // Flow control
    logic s2_ready;
    logic in_ready;
    logic in_fire;
    logic s1_adv;

    // Stage 1
    logic [WIDTH-1:0]            b_eff;
    logic [WIDTH-1:0]            bit_g;
    logic [WIDTH-1:0]            bit_p;
    gp_t  [WIDTH-1:0]            s1_bits_d, s1_bits_q;
    gp_t  [NUM_GROUPS-1:0]       s1_grp_d, s1_grp_q;
    logic                        s1_c0_d, s1_c0_q;
    logic                        s1_valid_d, s1_valid_q;

    // Stage 2
    logic [WIDTH-1:0]            s1_g;
    logic [WIDTH-1:0]            s1_p;
    logic [NUM_GROUPS-1:0]       grp_g;
    logic [NUM_GROUPS-1:0]       grp_p;
    logic [NUM_GROUPS:0]         grp_c;
    logic [NUM_GROUPS-1:0]       chk_gg;
    logic [NUM_GROUPS-1:0]       chk_pg;
    logic [WIDTH-1:0]            sum_d, sum_q;
    logic                        cout_d, cout_q;
    logic                        ovf_d, ovf_q;
    logic                        out_valid_d, out_valid_q;

    assign s2_ready = !out_valid_q || bus.out_ready_i;
    assign in_ready = !s1_valid_q || s2_ready;
    assign in_fire  = bus.in_valid_i && in_ready;
    assign s1_adv   = s1_valid_q && s2_ready;

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.sum_o       = sum_q;
    assign bus.cout_o      = cout_q;
    assign bus.ovf_o       = ovf_q;

    // Stage-1 operand conditioning and bit/group generate-propagate terms.
    always_comb begin
        s1_bits_d = '0;
        s1_grp_d  = '0;
        b_eff     = bus.sub_i ? ~bus.b_i : bus.b_i;
        bit_g     = bus.a_i & b_eff;
        bit_p     = bus.a_i ^ b_eff;
        s1_c0_d   = bus.sub_i ? 1'b1 : bus.cin_i;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s1_bits_d[i].g = bit_g[i];
            s1_bits_d[i].p = bit_p[i];
        end
        for (int unsigned k = 0; k < NUM_GROUPS; k++) begin
            s1_grp_d[k].g = cla_gen(CLA_MAX_N'(bit_g[k*GROUP_W +: GROUP_W]),
                                    CLA_MAX_N'(bit_p[k*GROUP_W +: GROUP_W]), GROUP_W);
            s1_grp_d[k].p = &bit_p[k*GROUP_W +: GROUP_W];
        end
    end

    // Stage-1 occupancy: a new beat wins over draining to the output register.
    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage-1 pipeline register, loaded on each accepted operand beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_bits_q  <= '0;
            s1_grp_q   <= '0;
            s1_c0_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_bits_q <= s1_bits_d;
                s1_grp_q  <= s1_grp_d;
                s1_c0_q   <= s1_c0_d;
            end
        end
    end

    // Stage-2 group carries resolved in parallel from the registered group terms.
    always_comb begin
        s1_g  = '0;
        s1_p  = '0;
        grp_g = '0;
        grp_p = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s1_g[i] = s1_bits_q[i].g;
            s1_p[i] = s1_bits_q[i].p;
        end
        for (int unsigned k = 0; k < NUM_GROUPS; k++) begin
            grp_g[k] = s1_grp_q[k].g;
            grp_p[k] = s1_grp_q[k].p;
        end
        grp_c = (NUM_GROUPS+1)'(cla_carries(CLA_MAX_N'(grp_g), CLA_MAX_N'(grp_p),
                                            s1_c0_q, NUM_GROUPS));
    end

    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_grp
        cla_group #(
            .GROUP_W(GROUP_W)
        ) u_grp (
            .p_i   (s1_p[k*GROUP_W +: GROUP_W]),
            .g_i   (s1_g[k*GROUP_W +: GROUP_W]),
            .cin_i (grp_c[k]),
            .sum_o (sum_d[k*GROUP_W +: GROUP_W]),
            .gg_o  (chk_gg[k]),
            .pg_o  (chk_pg[k])
        );
    end

    // Carry out and overflow; the carry into the MSB is recovered as p ^ sum there.
    always_comb begin
        cout_d      = grp_c[NUM_GROUPS];
        ovf_d       = (s1_p[WIDTH-1] ^ sum_d[WIDTH-1]) ^ grp_c[NUM_GROUPS];
        out_valid_d = s2_ready ? s1_valid_q : out_valid_q;
    end

    // Output register: holds while stalled, otherwise takes whatever stage 1 offers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s1_adv) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    // Group terms recomputed from the registered bits must agree with the registered ones.
    a_group_terms: assert property (@(posedge clk_i) disable iff (!rst_ni)
        s1_valid_q |-> ((chk_gg == grp_g) && (chk_pg == grp_p)));

endmodule

// File: tb/tb_cla_adder_pipe.sv
module tb_cla_adder_pipe;

    localparam int unsigned W = 20;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int unsigned  cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    cla_adder_pipe_if #(.WIDTH(W)) bus ();

    cla_adder_pipe #(
        .WIDTH   (W),
        .GROUP_W (5)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;
    bit          lat_chk = 1'b0;
    bit          rnd_on  = 1'b0;
    exp_t        q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic on the conditioned operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic sub, input logic cin);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] beff;
        logic         c0;
        beff   = sub ? ~b : b;
        c0     = sub ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, beff} + (W+1)'(c0);
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == beff[W-1]) && (e.sum[W-1] != a[W-1]);
        e.cyc  = 0;
        return e;
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_extra: got sum %h with no beat outstanding, expected none", bus.sum_o);
                end else begin
                    e = q.pop_front();
                    chk("sb_sum", 32'(bus.sum_o), 32'(e.sum));
                    chk("sb_cout", 32'(bus.cout_o), 32'(e.cout));
                    chk("sb_ovf", 32'(bus.ovf_o), 32'(e.ovf));
                    if (lat_chk) chk("sb_latency", cyc - e.cyc, 32'd2);
                end
            end
            if (prev_stall && bus.out_valid_o) begin
                chk("stall_sum", 32'(bus.sum_o), 32'(prev_sum));
                chk("stall_flags", {30'd0, bus.cout_o, bus.ovf_o}, {30'd0, prev_cout, prev_ovf});
            end
            prev_stall = bus.out_valid_o && !bus.out_ready_i;
            prev_sum   = bus.sum_o;
            prev_cout  = bus.cout_o;
            prev_ovf   = bus.ovf_o;
            if (bus.in_valid_i && bus.in_ready_o) begin
                e     = model(bus.a_i, bus.b_i, bus.sub_i, bus.cin_i);
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    // Offer one beat starting at posedge+1; returns just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
        int unsigned n;
        n = 0;
        bus.in_valid_i = 1'b1;
        bus.a_i        = a;
        bus.b_i        = b;
        bus.sub_i      = sub;
        bus.cin_i      = cin;
        @(negedge clk);
        while (!bus.in_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready_o) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready %b after 200 cycles, expected 1", bus.in_ready_o);
        end
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    // Single beat into an empty pipe with out_ready high, checked against literals.
    task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic sub, input logic cin,
                           input logic [W-1:0] xs, input logic xc, input logic xo);
        send(a, b, sub, cin);
        @(negedge clk);
        chk({name, "_fill"}, 32'(bus.out_valid_o), 32'd0);
        @(negedge clk);
        chk({name, "_valid"}, 32'(bus.out_valid_o), 32'd1);
        chk({name, "_sum"}, 32'(bus.sum_o), 32'(xs));
        chk({name, "_cout"}, 32'(bus.cout_o), 32'(xc));
        chk({name, "_ovf"}, 32'(bus.ovf_o), 32'(xo));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int unsigned n;
        n = 0;
        while ((q.size() != 0 || bus.out_valid_o) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.sub_i       = 1'b0;
        bus.cin_i       = 1'b0;
        bus.out_ready_i = 1'b1;
        rst_n           = 1'b0;

        #12;
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_data", {11'd0, bus.sum_o, bus.cout_o}, 32'd0);
        chk("rst_ovf", 32'(bus.ovf_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready_o), 32'd1);

        // Directed vectors with latency check
        lat_chk = 1'b1;
        run_vec("add_chain", 20'hFFFFF, 20'h00001, 1'b0, 1'b0, 20'h00000, 1'b1, 1'b0);
        run_vec("sub_borrow", 20'h00005, 20'h00007, 1'b1, 1'b0, 20'hFFFFE, 1'b0, 1'b0);
        run_vec("sub_noborrow", 20'h00007, 20'h00005, 1'b1, 1'b0, 20'h00002, 1'b1, 1'b0);
        run_vec("add_ovf", 20'h7FFFF, 20'h00001, 1'b0, 1'b0, 20'h80000, 1'b0, 1'b1);
        run_vec("sub_ovf", 20'h80000, 20'h00001, 1'b1, 1'b0, 20'h7FFFF, 1'b1, 1'b1);
        run_vec("add_cin", 20'h12345, 20'h0ABCD, 1'b0, 1'b1, 20'h1CF13, 1'b0, 1'b0);
        run_vec("sub_ign_cin", 20'h00010, 20'h00010, 1'b1, 1'b1, 20'h00000, 1'b1, 1'b0);
        run_vec("cin_chain", 20'hFFFFF, 20'h00000, 1'b0, 1'b1, 20'h00000, 1'b1, 1'b0);

        // Backpressure: two beats fill the pipe, third waits
        lat_chk = 1'b0;
        bus.out_ready_i = 1'b0;
        send(20'h00100, 20'h00023, 1'b0, 1'b0);
        send(20'h00050, 20'h00010, 1'b1, 1'b0);
        fork
            send(20'hFFFFF, 20'hFFFFF, 1'b0, 1'b1);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(bus.in_ready_o), 32'd0);
                    chk("bp_out_valid", 32'(bus.out_valid_o), 32'd1);
                    chk("bp_sum", 32'(bus.sum_o), 32'h00123);
                end
                @(posedge clk);
                #1;
                bus.out_ready_i = 1'b1;
            end
        join
        drain("bp_drain");

        // Throughput: back-to-back beats, every result exactly 2 cycles later
        lat_chk = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        drain("tp_drain");

        // Random valid gaps and ready toggling
        lat_chk = 1'b0;
        rnd_on  = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                bus.out_ready_i = 1'($urandom_range(0, 1));
            end
            begin
                for (int i = 0; i < 100; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
                end
                rnd_on = 1'b0;
            end
        join
        bus.out_ready_i = 1'b1;
        drain("rnd_drain");

        // Reset with two beats in flight
        bus.out_ready_i = 1'b0;
        send(20'h00AAA, 20'h00555, 1'b0, 1'b0);
        send(20'h00123, 20'h00001, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("mid_rst_sum", 32'(bus.sum_o), 32'd0);
        chk("mid_rst_flags", {30'd0, bus.cout_o, bus.ovf_o}, 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready_i = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("no_stale", 32'(bus.out_valid_o), 32'd0);
        end
        chk("post_mid_rst_in_ready", 32'(bus.in_ready_o), 32'd1);
        @(posedge clk);
        #1;
        lat_chk = 1'b1;
        run_vec("after_rst", 20'h00003, 20'h00004, 1'b0, 1'b0, 20'h00007, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cla_adder_pipe.md
Name: cla_adder_pipe

Overview:
- Parametrised, two-stage pipelined carry-lookahead adder/subtractor built from GROUP_W-bit lookahead groups. A second lookahead level combines the groups' generate/propagate terms.
- Successor to the fixed 5-bit group for NPU accumulator and address datapaths.
- Adds add/sub mode, signed overflow, valid/ready flow control with backpressure, and one result per cycle throughput.

Parameters:
- WIDTH, 20, operand and result width; must be an integer multiple of GROUP_W (elaboration-time assertion).
- GROUP_W, 5, bits per lookahead group.
- NUM_GROUPS, WIDTH/GROUP_W, derived localparam; not overridable.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  operand beat valid.
- in_ready_o  output  1  block can accept an operand beat.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- sub_i  input  1  0: A+B+cin_i; 1: A-B (A + ~B + 1).
- cin_i  input  1  carry in; ignored when sub_i=1.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  downstream accepts result.
- sum_o  output  WIDTH  result.
- cout_o  output  1  carry out of the MSB; for subtraction, 1 means no borrow.
- ovf_o  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (async assert, sync-safe deassert path): s1_valid=0, out_valid_o=0, sum_o=0, cout_o=0, ovf_o=0. in_ready_o=1 while reset is asserted and after it is released.
- Transfer occurs on a cycle with valid&ready high at a rising edge; on each side this is the only acceptance event.
- Stage 1 (registered at input transfer):
  - b_eff = sub_i ? ~b_i : b_i; c0 = sub_i ? 1 : cin_i.
  - Per bit: g = a&b_eff, p = a^b_eff.
  - Per group: Gg, Pg computed as full-parallel lookahead, no internal ripple.
  - Registered into s1: per-bit p and g, per-group Gg and Pg, c0, s1_valid=1.
- Stage 2 (combinational from s1, registered into output):
  - Group carries: C[0]=c0, C[k+1]=Gg[k] | Pg[k]&C[k], expanded as parallel sum-of-products over all lower groups, not rippled.
  - In-group carries: lookahead from C[k]; sum = p ^ c.
  - cout_o = C[NUM_GROUPS].
  - ovf_o = c[WIDTH-1] ^ C[NUM_GROUPS].
- Latency: a result is visible on out_valid_o exactly 2 cycles after input transfer when there is no stall.
- Throughput: 1 beat per cycle when out_ready_i is held high.
- Flow control (bubble-collapsing):
  - s2_ready = !out_valid_o | out_ready_i.
  - in_ready_o = !s1_valid | s2_ready (combinational, no dependence on in_valid_i).
  - s1 advances into the output register when s1_valid & s2_ready.
  - When s1 advances and there is no new input, s1_valid clears.
- Stall: while out_valid_o=1 & out_ready_i=0, sum_o, cout_o and ovf_o stay stable and s1 is held. The pipe therefore holds at most 2 beats before in_ready_o drops.
- Simultaneous events:
  - Output transfer and stage-1 advance in the same cycle: the output register loads the new s1 result, and out_valid_o stays 1.
  - Input accept and s1 advance in the same cycle: s1 loads the new beat.
- Empty pipe: out_valid_o=0 and the data outputs hold their last values. Bench must not check data when out_valid_o=0.
- Reset mid-operation: all in-flight beats are discarded and no result is emitted after release.
- Wrap-around: the sum is modulo 2^WIDTH. Carry is reported only via cout_o.

Decomposition:
- Package cla_pkg:
  - gp_t struct {g, p}.
  - Function cla_carries(G, P, cin) returning the parallel carry vector; used at both levels.
  - Default GROUP_W constant.
- Sub-module cla_group (parameter GROUP_W):
  - Inputs: p, g, cin.
  - Outputs: sum, Gg, Pg.
  - Instantiated NUM_GROUPS times in generate.
  - Combinational only; pipeline registers live in cla_adder_pipe.

Test Plan:
- Add with full carry chain: a=0xFFFFF, b=0x00001, sub=0, cin=0 -> 2 cycles later sum=0x00000, cout=1, ovf=0.
- Subtract with borrow: a=0x00005, b=0x00007, sub=1 -> sum=0xFFFFE, cout=0, ovf=0. Then a=7, b=5, sub=1 -> sum=0x00002, cout=1.
- Signed overflow: a=0x7FFFF, b=0x00001 add -> sum=0x80000, ovf=1, cout=0. Also a=0x80000, b=0x00001, sub=1 -> sum=0x7FFFF, ovf=1.
- Backpressure: out_ready_i=0 while 3 beats are offered back-to-back. Beats 1-2 are accepted, then in_ready_o=0 and out_valid_o=1 with sum stable. Raise out_ready_i -> 3 results in order, one per cycle, nothing lost or duplicated.
- Throughput: 100 random beats with in_valid=out_ready=1 -> exactly 1 result per cycle after 2-cycle fill, matching the reference model a±b+cin. Randomised ready/valid toggling -> same ordered results.
- Reset mid-flight: accept 2 beats, assert rst_ni low for 1 cycle -> all outputs 0 immediately, no stale results after release, and in_ready_o=1.
